pad_button_conditioner: RTL and testbench

- Upstream front-end for the pad test block's two manual controls: cycle-index (ui_in[6]) and toggle-config (ui_in[7]).
- Synchronises, debounces and edge-detects raw push-button levels into single-cycle pulses, so one physical press gives exactly one index step or one config-bit toggle.
- Optional auto-repeat per channel lets a held cycle button step through indices at a controlled rate.
- Output pulses drive the pad test block's cycle/toggle inputs directly.

---
 rtl/pad_button_conditioner_if.sv | 24 ++
 rtl/pad_button_conditioner.sv | 139 +++++++++++++
 tb/tb_pad_button_conditioner.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pad_button_conditioner_if.sv
// Button conditioner bus: raw button levels and enable in, conditioned pulses
// and held levels out. The DUT side uses the slave modport.
interface pad_button_conditioner_if #(
    parameter int NUM_BTN = 2
);
    logic               ena;
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] pulse_out;
    logic [NUM_BTN-1:0] held_out;

    modport master (
        output ena,
        output btn_in,
        input  pulse_out,
        input  held_out
    );

    modport slave (
        input  ena,
        input  btn_in,
        output pulse_out,
        output held_out
    );
endinterface

// File: rtl/pad_button_conditioner.sv
// Push-button front end: two-flop synchroniser, debounce FSM and optional
// auto-repeat per channel, producing one registered pulse per accepted press.
module pad_button_conditioner #(
    parameter int                 NUM_BTN         = 2,
    parameter int                 CNT_W           = 16,
    parameter int                 DEBOUNCE_CYCLES = 1000,
    parameter int                 REPEAT_DELAY    = 50000,
    parameter int                 REPEAT_PERIOD   = 20000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(1)
) (
    input logic                     clk,
    input logic                     rst_n,
    pad_button_conditioner_if.slave bus
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS_DB = 3'd1;
    localparam logic [2:0] ST_HELD     = 3'd2;
    localparam logic [2:0] ST_REPEAT   = 3'd3;
    localparam logic [2:0] ST_REL_DB   = 3'd4;

    // Terminal counts are stored as count-1 so the full 2^CNT_W range fits.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Synchroniser keeps running while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        logic [2:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pulse_q, pulse_d;
        logic             held_q, held_d;
        logic             s;

        assign s = sync2_q[g];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            if (!bus.ena) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (s) begin
                            state_d = ST_PRESS_DB;
                            cnt_d   = '0;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (!s) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!s) begin
                            state_d = ST_REL_DB;
                            cnt_d   = '0;
                        end else if (REPEAT_MASK[g] && (cnt_q == RD_LAST)) begin
                            state_d = ST_REPEAT;
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!s) begin
                            state_d = ST_REL_DB;
                            cnt_d   = '0;
                        end else if (cnt_q == RP_LAST) begin
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_REL_DB: begin
                        // A bounce during release returns to HELD without a new press.
                        if (s) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
            held_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) ||
                     (state_d == ST_REL_DB);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
                held_q  <= held_d;
            end
        end

        assign bus.pulse_out[g] = pulse_q;
        assign bus.held_out[g]  = held_q;
    end
endmodule

// File: tb/tb_pad_button_conditioner.sv
// Directed bench for pad_button_conditioner with a pulse scoreboard keyed by
// clock edge number; held_out is checked at chosen points in the sequence.
module tb_pad_button_conditioner;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pad_button_conditioner_if #(.NUM_BTN(2)) bus ();

    pad_button_conditioner #(
        .NUM_BTN        (2),
        .CNT_W          (16),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3),
        .REPEAT_MASK    (2'b01)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        int         e;
        logic [1:0] v;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;
    int   e0, m, r;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic push(input int e, input logic [1:0] v);
        exp_t x;
        x.e = e;
        x.v = v;
        sb.push_back(x);
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Every cycle, pulse_out must equal the scheduled value (0 if nothing due).
    always @(negedge clk) begin : mon
        logic [1:0] exp_v;
        exp_v = 2'b00;
        if (sb.size() > 0 && sb[0].e == edge_n) begin
            exp_v = sb[0].v;
            void'(sb.pop_front());
        end
        check("pulse", bus.pulse_out, exp_v);
    end

    initial begin
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.btn_in = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_pulse", bus.pulse_out, 2'b00);
        check("rst_held", bus.held_out, 2'b00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press on channel 0, held for 6 edges
        e0 = edge_n + 1;
        bus.btn_in[0] = 1'b1;
        push(e0 + 6, 2'b01);
        wait_edge(e0 + 5);
        check("clean_held_pre", bus.held_out, 2'b00);
        bus.btn_in[0] = 1'b0;
        wait_edge(e0 + 6);
        check("clean_held_rise", bus.held_out, 2'b01);
        wait_edge(e0 + 11);
        check("clean_held_hold", bus.held_out, 2'b01);
        wait_edge(e0 + 12);
        check("clean_held_fall", bus.held_out, 2'b00);
        wait_edge(e0 + 16);

        // Bounce on channel 1: 1,0,1,0 every 2 cycles
        for (int k = 0; k < 4; k++) begin
            bus.btn_in[1] = (k % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                check("bounce_held", {1'b0, bus.held_out[1]}, 2'b00);
            end
        end
        bus.btn_in[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("bounce_held_after", {1'b0, bus.held_out[1]}, 2'b00);
        end

        // Both held 30 cycles: repeat on channel 0 only
        e0 = edge_n + 1;
        bus.btn_in = 2'b11;
        push(e0 + 6, 2'b11);
        for (int t = 14; t <= 29; t += 3) push(e0 + t, 2'b01);
        wait_edge(e0 + 29);
        bus.btn_in = 2'b00;
        wait_edge(e0 + 31);
        check("rep_held", bus.held_out, 2'b11);
        wait_edge(e0 + 40);
        check("rep_held_after", bus.held_out, 2'b00);

        // Release bounce on channel 0
        e0 = edge_n + 1;
        bus.btn_in[0] = 1'b1;
        push(e0 + 6, 2'b01);
        for (int t = 5; t <= 20; t++) begin
            wait_edge(e0 + t);
            check("relb_held", bus.held_out, (t >= 6 && t <= 19) ? 2'b01 : 2'b00);
            if (t == 7)  bus.btn_in[0] = 1'b0;
            if (t == 9)  bus.btn_in[0] = 1'b1;
            if (t == 13) bus.btn_in[0] = 1'b0;
        end
        wait_edge(e0 + 26);

        // Simultaneous short press
        e0 = edge_n + 1;
        bus.btn_in = 2'b11;
        push(e0 + 6, 2'b11);
        wait_edge(e0 + 5);
        bus.btn_in = 2'b00;
        wait_edge(e0 + 6);
        check("sim_held", bus.held_out, 2'b11);
        wait_edge(e0 + 16);
        check("sim_held_after", bus.held_out, 2'b00);

        // Asynchronous reset while channel 0 is repeating
        e0 = edge_n + 1;
        bus.btn_in[0] = 1'b1;
        push(e0 + 6, 2'b01);
        push(e0 + 14, 2'b01);
        wait_edge(e0 + 15);
        check("rep_held_pre_rst", bus.held_out, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pulse", bus.pulse_out, 2'b00);
        check("rst_async_held", bus.held_out, 2'b00);
        wait_edge(e0 + 17);
        check("rst_held_low", bus.held_out, 2'b00);
        rst_n = 1'b1;
        r = edge_n;
        push(r + 7, 2'b01);
        wait_edge(r + 6);
        check("postrst_held_pre", bus.held_out, 2'b00);
        wait_edge(r + 7);
        check("postrst_held", bus.held_out, 2'b01);
        wait_edge(r + 8);
        bus.btn_in[0] = 1'b0;
        wait_edge(r + 20);
        check("postrst_held_after", bus.held_out, 2'b00);

        // One-cycle ena drop while channel 1 is held
        e0 = edge_n + 1;
        bus.btn_in[1] = 1'b1;
        push(e0 + 6, 2'b10);
        wait_edge(e0 + 8);
        check("ena_held_pre", bus.held_out, 2'b10);
        bus.ena = 1'b0;
        m = edge_n;
        wait_edge(m + 1);
        check("ena_held_clear", bus.held_out, 2'b00);
        bus.ena = 1'b1;
        push(m + 6, 2'b10);
        wait_edge(m + 5);
        check("ena_redb_held", bus.held_out, 2'b00);
        wait_edge(m + 6);
        check("ena_repress_held", bus.held_out, 2'b10);
        bus.btn_in[1] = 1'b0;
        wait_edge(m + 16);
        check("ena_held_after", bus.held_out, 2'b00);

        repeat (4) @(negedge clk);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drained observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
